// File: rtl/pll_reset_seq.sv
`default_nettype none
// ============================================================================
//  Module      : pll_reset_seq
//  Description : Reset sequencer for the PLL clock domain. Holds the system
//                reset asserted until the PLL lock flag has been stable for a
//                programmable time. Re-enters reset whenever lock is lost in
//                RUN, and counts those lock-loss events for debug.
//  Ports       : clock_i           PLL global-buffer clock (rising edge)
//                reset_i           async active-high reset
//                locked_i          PLL lock flag (asynchronous to clock_i)
//                clear_sticky_i    sync pulse, clears lock_lost_o
//                sys_reset_o       registered active-high system reset
//                sys_reset_n_o     registered complement of sys_reset_o
//                ready_o           registered, high only in RUN
//                lock_lost_o       sticky flag set on every RUN->HOLD exit
//                lock_loss_count_o saturating count of RUN->HOLD exits
//  Revision    : 1.0  initial release
// ============================================================================
module pll_reset_seq #(
    parameter int HOLD_CYCLES   = 16,
    parameter int STABLE_CYCLES = 1024,
    parameter int SYNC_STAGES   = 2,
    parameter int LOSS_CNT_W    = 8
) (
    input  logic                  clock_i,
    input  logic                  reset_i,
    input  logic                  locked_i,
    input  logic                  clear_sticky_i,
    output logic                  sys_reset_o,
    output logic                  sys_reset_n_o,
    output logic                  ready_o,
    output logic                  lock_lost_o,
    output logic [LOSS_CNT_W-1:0] lock_loss_count_o
);

    localparam int CNT_MAX = (HOLD_CYCLES > STABLE_CYCLES) ? HOLD_CYCLES : STABLE_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX) + 1;

    localparam logic [CNT_W-1:0]      C_HOLD_LAST   = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0]      C_STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0]      C_CNT_ONE     = CNT_W'(1);
    localparam logic [LOSS_CNT_W-1:0] C_LOSS_ONE    = LOSS_CNT_W'(1);

    typedef enum logic [1:0] {
        ST_HOLD      = 2'd0,
        ST_WAIT_LOCK = 2'd1,
        ST_STABILIZE = 2'd2,
        ST_RUN       = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // Reset release synchroniser: asserts with reset_i, releases after the
    // second rising edge following reset_i deassertion.
    // ------------------------------------------------------------------
    logic [1:0] rst_sync_q;
    logic       rst_int;

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            rst_sync_q <= 2'b11;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b0};
        end
    end

    assign rst_int = rst_sync_q[1];

    // ------------------------------------------------------------------
    // Lock flag synchroniser; only locked_s is used downstream.
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] lock_sync_q;
    logic                   locked_s;

    always_ff @(posedge clock_i or posedge rst_int) begin
        if (rst_int) begin
            lock_sync_q <= '0;
        end else begin
            lock_sync_q <= {lock_sync_q[SYNC_STAGES-2:0], locked_i};
        end
    end

    assign locked_s = lock_sync_q[SYNC_STAGES-1];

    // ------------------------------------------------------------------
    // Sequencer FSM
    // ------------------------------------------------------------------
    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    loss_evt;
    logic [LOSS_CNT_W-1:0]   loss_cnt_q, loss_cnt_d;
    logic                    lost_q, lost_d;
    logic                    sys_reset_q, sys_reset_n_q, ready_q;

    always_ff @(posedge clock_i or posedge rst_int) begin
        if (rst_int) begin
            state_q       <= ST_HOLD;
            cnt_q         <= '0;
            loss_cnt_q    <= '0;
            lost_q        <= 1'b0;
            sys_reset_q   <= 1'b1;
            sys_reset_n_q <= 1'b0;
            ready_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            loss_cnt_q    <= loss_cnt_d;
            lost_q        <= lost_d;
            // Decoded from the next state so the reset output moves on the
            // same edge as the state register.
            sys_reset_q   <= (state_d != ST_RUN);
            sys_reset_n_q <= (state_d == ST_RUN);
            ready_q       <= (state_d == ST_RUN);
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        loss_evt = 1'b0;

        case (state_q)
            ST_HOLD: begin
                if (cnt_q == C_HOLD_LAST) begin
                    state_d = ST_WAIT_LOCK;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + C_CNT_ONE;
                end
            end
            ST_WAIT_LOCK: begin
                if (locked_s) begin
                    state_d = ST_STABILIZE;
                    cnt_d   = '0;
                end
            end
            ST_STABILIZE: begin
                // A drop before release is not a loss event; restart the wait.
                if (!locked_s) begin
                    state_d = ST_WAIT_LOCK;
                    cnt_d   = '0;
                end else if (cnt_q == C_STABLE_LAST) begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + C_CNT_ONE;
                end
            end
            ST_RUN: begin
                if (!locked_s) begin
                    state_d  = ST_HOLD;
                    cnt_d    = '0;
                    loss_evt = 1'b1;
                end
            end
            default: begin
                state_d = ST_HOLD;
                cnt_d   = '0;
            end
        endcase
    end

    // Loss bookkeeping: the count saturates, and a loss overrides a
    // simultaneous clear request on the sticky flag.
    always_comb begin
        loss_cnt_d = loss_cnt_q;
        lost_d     = lost_q;
        if (loss_evt) begin
            lost_d = 1'b1;
            if (loss_cnt_q != {LOSS_CNT_W{1'b1}}) begin
                loss_cnt_d = loss_cnt_q + C_LOSS_ONE;
            end
        end else if (clear_sticky_i) begin
            lost_d = 1'b0;
        end
    end

    assign sys_reset_o       = sys_reset_q;
    assign sys_reset_n_o     = sys_reset_n_q;
    assign ready_o           = ready_q;
    assign lock_lost_o       = lost_q;
    assign lock_loss_count_o = loss_cnt_q;

endmodule
`default_nettype wire
